// File: rtl/branch_resolve_queue.sv
// Tracks predicted branches in program order until execute resolves them,
// emitting BHT training pulses and mispredict flush/redirect with recovery stall.
module branch_resolve_queue #(
  parameter int DEPTH       = 4,
  parameter int PTR_W       = 2,
  parameter int RECOVER_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [31:0]      push_pc,
  input  logic             push_pred_taken,
  input  logic [31:0]      push_alt_pc,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  input  logic [31:0]      resolve_pc,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic             stall,
  output logic             update,
  output logic [31:0]      updatePC,
  output logic             branchResult,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic [15:0]      mispredict_count,
  output logic             err_overflow,
  output logic             err_underflow,
  output logic             err_order
);

  localparam int CW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
  localparam int RL = RECOVER_CYC - 1;
  localparam logic [CW-1:0] RECOVER_LOAD = RL[CW-1:0];
  localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

  typedef enum logic {IDLE, RECOVER} state_t;

  state_t state, stateNext;
  logic [CW-1:0] recCnt, recCntNext;

  logic [31:0] pcMem   [DEPTH];
  logic        predMem [DEPTH];
  logic [31:0] altMem  [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic pop, mispredict, pushOk, overflow, underflow, orderBad;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign stall = (state == RECOVER);

  assign pop        = resolve_valid && !empty;
  assign mispredict = pop && (resolve_taken != predMem[head]);
  assign pushOk     = push && (state == IDLE) && !mispredict
                      && (!full || pop);
  // Pushes during recovery are the expected squash, not an overflow.
  assign overflow   = push && (state == IDLE) && full && !pop;
  assign underflow  = resolve_valid && empty;
  assign orderBad   = pop && (resolve_pc != pcMem[head]);

  always_comb begin
    stateNext  = state;
    recCntNext = recCnt;
    unique case (state)
      IDLE: begin
        if (mispredict) begin
          stateNext  = RECOVER;
          recCntNext = RECOVER_LOAD;
        end
      end
      RECOVER: begin
        if (recCnt == '0) stateNext = IDLE;
        else recCntNext = recCnt - 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      recCnt           <= '0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      update           <= 1'b0;
      flush            <= 1'b0;
      updatePC         <= '0;
      branchResult     <= 1'b0;
      redirect_pc      <= '0;
      mispredict_count <= '0;
      err_overflow     <= 1'b0;
      err_underflow    <= 1'b0;
      err_order        <= 1'b0;
    end else begin
      state  <= stateNext;
      recCnt <= recCntNext;
      update <= pop;
      flush  <= mispredict;
      if (pop) begin
        updatePC     <= pcMem[head];
        branchResult <= resolve_taken;
      end
      if (mispredict) begin
        redirect_pc <= altMem[head];
        head        <= tail;
        count       <= '0;
        if (mispredict_count != '1)
          mispredict_count <= mispredict_count + 1'b1;
      end else begin
        if (pop) head <= head + 1'b1;
        if (pushOk) tail <= tail + 1'b1;
        count <= count + {{PTR_W{1'b0}}, pushOk}
                       - {{PTR_W{1'b0}}, pop};
      end
      if (overflow) err_overflow <= 1'b1;
      if (underflow) err_underflow <= 1'b1;
      if (orderBad) err_order <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) begin
      pcMem[tail]   <= push_pc;
      predMem[tail] <= push_pred_taken;
      altMem[tail]  <= push_alt_pc;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed vector table, hand sequences,
// and random traffic checked against a queue-based reference model.
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int RECOVER_CYC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, push, push_pred_taken, resolve_valid, resolve_taken;
  logic [31:0] push_pc, push_alt_pc, resolve_pc;
  logic        full, empty, stall, update, branchResult, flush;
  logic [PTR_W:0] count;
  logic [31:0] updatePC, redirect_pc;
  logic [15:0] mispredict_count;
  logic        err_overflow, err_underflow, err_order;

  branch_resolve_queue #(
    .DEPTH(DEPTH), .PTR_W(PTR_W), .RECOVER_CYC(RECOVER_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .push(push), .push_pc(push_pc),
    .push_pred_taken(push_pred_taken), .push_alt_pc(push_alt_pc),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_pc(resolve_pc),
    .full(full), .empty(empty), .count(count), .stall(stall),
    .update(update), .updatePC(updatePC), .branchResult(branchResult),
    .flush(flush), .redirect_pc(redirect_pc),
    .mispredict_count(mispredict_count),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .err_order(err_order)
  );

  int nChk = 0;
  int nPass = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [91:0] obs();
    return {count, full, empty, stall, update, updatePC, branchResult,
            flush, redirect_pc, mispredict_count,
            err_overflow, err_underflow, err_order};
  endfunction

  task automatic drive(input logic r, input logic p,
                       input logic [31:0] pc, input logic pt,
                       input logic [31:0] alt, input logic rv,
                       input logic rt, input logic [31:0] rpc);
    rst = r; push = p; push_pc = pc; push_pred_taken = pt;
    push_alt_pc = alt; resolve_valid = rv; resolve_taken = rt;
    resolve_pc = rpc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic r, p; logic [31:0] pc; logic pt; logic [31:0] alt;
    logic rv, rt; logic [31:0] rpc;
    logic [2:0] eCnt; logic eStall, eUpd; logic [31:0] eUpc;
    logic eBr, eFl; logic [31:0] eRd; logic [2:0] eErr;
    logic [15:0] eMc;
  } vec_t;

  function automatic vec_t v(
    logic r, logic p, logic [31:0] pc, logic pt, logic [31:0] alt,
    logic rv, logic rt, logic [31:0] rpc,
    logic [2:0] c, logic s, logic u, logic [31:0] upc,
    logic b, logic f, logic [31:0] rd, logic [2:0] e, logic [15:0] m);
    vec_t x;
    x.r = r; x.p = p; x.pc = pc; x.pt = pt; x.alt = alt;
    x.rv = rv; x.rt = rt; x.rpc = rpc;
    x.eCnt = c; x.eStall = s; x.eUpd = u; x.eUpc = upc;
    x.eBr = b; x.eFl = f; x.eRd = rd; x.eErr = e; x.eMc = m;
    return x;
  endfunction

  // Reference model: a plain queue plus held output values.
  typedef struct {
    logic [31:0] pc; logic pt; logic [31:0] alt;
  } ent_t;
  ent_t mq[$];
  int mStall;
  logic mUpd, mBr, mFl, mOvf, mUnd, mOrd;
  logic [31:0] mUpc, mRd;
  logic [15:0] mMc;

  task automatic modelStep(input logic r, input logic p,
                           input logic [31:0] pc, input logic pt,
                           input logic [31:0] alt, input logic rv,
                           input logic rt, input logic [31:0] rpc);
    bit inRec, mis;
    ent_t h, n;
    mUpd = 0; mFl = 0; mis = 0;
    if (r) begin
      mq.delete(); mStall = 0; mUpc = 0; mBr = 0; mRd = 0; mMc = 0;
      mOvf = 0; mUnd = 0; mOrd = 0;
    end else begin
      inRec = (mStall > 0);
      if (mStall > 0) mStall--;
      if (rv && mq.size() == 0) mUnd = 1;
      if (rv && mq.size() > 0) begin
        h = mq.pop_front();
        mUpd = 1; mUpc = h.pc; mBr = rt;
        if (rpc != h.pc) mOrd = 1;
        if (rt != h.pt) begin
          mis = 1; mFl = 1; mRd = h.alt; mq.delete();
          mStall = RECOVER_CYC;
          if (mMc != 16'hFFFF) mMc++;
        end
      end
      if (p && !inRec && !mis) begin
        if (mq.size() < DEPTH) begin
          n.pc = pc; n.pt = pt; n.alt = alt;
          mq.push_back(n);
        end else mOvf = 1;
      end
    end
  endtask

  function automatic logic [91:0] mExp();
    logic [2:0] c;
    c = 3'(mq.size());
    return {c, c == 3'(DEPTH), c == 3'd0, mStall > 0, mUpd, mUpc, mBr,
            mFl, mRd, mMc, mOvf, mUnd, mOrd};
  endfunction

  vec_t tv[20];

  initial begin
    tv[0]  = v(1,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0,0,0);
    tv[1]  = v(0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0,0,0);
    tv[2]  = v(0,1,'h100,1,'h108, 0,0,0, 1,0,0,0,0,0,0,0,0);
    tv[3]  = v(0,0,0,0,0, 1,1,'h100, 0,0,1,'h100,1,0,0,0,0);
    tv[4]  = v(0,1,'h100,1,'h108, 0,0,0, 1,0,0,'h100,1,0,0,0,0);
    tv[5]  = v(0,1,'h200,0,'h240, 0,0,0, 2,0,0,'h100,1,0,0,0,0);
    tv[6]  = v(0,0,0,0,0, 1,0,'h100, 0,1,1,'h100,0,1,'h108,0,1);
    tv[7]  = v(0,1,'h300,1,'h304, 0,0,0, 0,1,0,'h100,0,0,'h108,0,1);
    tv[8]  = v(0,0,0,0,0, 0,0,0, 0,0,0,'h100,0,0,'h108,0,1);
    tv[9]  = v(0,1,'h10,1,'h14, 0,0,0, 1,0,0,'h100,0,0,'h108,0,1);
    tv[10] = v(0,1,'h20,1,'h24, 0,0,0, 2,0,0,'h100,0,0,'h108,0,1);
    tv[11] = v(0,1,'h30,1,'h34, 0,0,0, 3,0,0,'h100,0,0,'h108,0,1);
    tv[12] = v(0,1,'h40,1,'h44, 0,0,0, 4,0,0,'h100,0,0,'h108,0,1);
    tv[13] = v(0,1,'h50,1,'h54, 0,0,0, 4,0,0,'h100,0,0,'h108,4,1);
    tv[14] = v(0,1,'h60,1,'h64, 1,1,'h10, 4,0,1,'h10,1,0,'h108,4,1);
    tv[15] = v(0,0,0,0,0, 1,1,'h20, 3,0,1,'h20,1,0,'h108,4,1);
    tv[16] = v(0,0,0,0,0, 1,1,'h30, 2,0,1,'h30,1,0,'h108,4,1);
    tv[17] = v(0,0,0,0,0, 1,1,'h99, 1,0,1,'h40,1,0,'h108,5,1);
    tv[18] = v(0,0,0,0,0, 1,1,'h60, 0,0,1,'h60,1,0,'h108,5,1);
    tv[19] = v(0,0,0,0,0, 1,0,0, 0,0,0,'h60,1,0,'h108,7,1);

    drive(1,0,0,0,0,0,0,0);

    for (int i = 0; i < 20; i++) begin
      drive(tv[i].r, tv[i].p, tv[i].pc, tv[i].pt, tv[i].alt,
            tv[i].rv, tv[i].rt, tv[i].rpc);
      tick();
      chk($sformatf("vec%0d", i), obs(),
          {tv[i].eCnt, tv[i].eCnt == 3'd4, tv[i].eCnt == 3'd0,
           tv[i].eStall, tv[i].eUpd, tv[i].eUpc, tv[i].eBr, tv[i].eFl,
           tv[i].eRd, tv[i].eMc, tv[i].eErr});
    end

    // Reset while recovering from a mispredict.
    drive(1,0,0,0,0,0,0,0);
    tick();
    chk("rstClear", {stall, count, mispredict_count, redirect_pc,
        err_overflow, err_underflow, err_order}, '0);
    drive(0,1,'h500,1,'h508,0,0,0);
    tick();
    drive(0,0,0,0,0,1,0,'h500);
    tick();
    chk("misFlush", {flush, stall, redirect_pc, count, mispredict_count},
        {1'b1, 1'b1, 32'h508, 3'd0, 16'd1});
    drive(1,0,0,0,0,0,0,0);
    tick();
    chk("rstInRec", {stall, count, mispredict_count, flush, update}, '0);
    drive(0,1,'h600,1,'h608,0,0,0);
    tick();
    chk("pushAfterRst", {count, stall}, {3'd1, 1'b0});

    // Random traffic against the model.
    drive(1,0,0,0,0,0,0,0);
    modelStep(1,0,0,0,0,0,0,0);
    tick();
    chk("randRst", obs(), mExp());
    for (int i = 0; i < 3000; i++) begin
      logic r, p, pt, rv, rt;
      logic [31:0] pc, alt, rpc;
      r   = ($urandom_range(0, 99) == 0);
      p   = ($urandom_range(0, 1) == 1);
      pc  = {$urandom_range(0, 'hFFFF), 2'b00};
      pt  = ($urandom_range(0, 1) == 1);
      alt = {$urandom_range(0, 'hFFFF), 2'b00};
      rv  = ($urandom_range(0, 2) == 0);
      rt  = ($urandom_range(0, 1) == 1);
      if (mq.size() > 0 && $urandom_range(0, 9) != 0) rpc = mq[0].pc;
      else rpc = $urandom;
      modelStep(r, p, pc, pt, alt, rv, rt, rpc);
      drive(r, p, pc, pt, alt, rv, rt, rpc);
      tick();
      chk($sformatf("rand%0d", i), obs(), mExp());
    end

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Tracks every branch prediction issued by the fetch stage, in program order, until the execute stage resolves it.
- On each resolution it produces the one-cycle update pulse, updatePC and branchResult that train the 2-bit BHT predictor.
- On a misprediction it also flushes the fetch path, supplies the correct redirect PC, and holds off new pushes for a fixed recovery window.

Parameters:
DEPTH, 4, number of outstanding predicted branches held (power of two, >=2)
PTR_W, 2, log2(DEPTH)
RECOVER_CYC, 2, cycles new pushes are blocked after a flush (>=1)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
push  input  1  fetch issued a predicted branch this cycle
push_pc  input  32  PC of the predicted branch
push_pred_taken  input  1  predicted direction (BHT state bit 1)
push_alt_pc  input  32  PC not chosen (notTakenPC if predicted taken, else takenPC)
resolve_valid  input  1  execute resolved the oldest outstanding branch
resolve_taken  input  1  actual direction
resolve_pc  input  32  PC of the resolved branch, for order checking
full  output  1  DEPTH entries held
empty  output  1  no entries held
count  output  PTR_W+1  entries held
stall  output  1  high while in RECOVER
update  output  1  one-cycle pulse to predictor
updatePC  output  32  PC of the branch being trained
branchResult  output  1  actual direction for training
flush  output  1  one-cycle pulse: squash younger fetched instructions
redirect_pc  output  32  correct fetch target, valid when flush=1
mispredict_count  output  16  saturating count of mispredictions
err_overflow  output  1  sticky: push dropped while full
err_underflow  output  1  sticky: resolve with queue empty
err_order  output  1  sticky: resolve_pc != head PC

Behaviour:
- Reset: queue emptied (head=tail=0, count=0), empty=1, full=0, stall=0, update=0, flush=0, updatePC=0, branchResult=0, redirect_pc=0, mispredict_count=0, all err_* flags=0, state=IDLE.
- Storage: circular FIFO of {pc, pred_taken, alt_pc}. Head and tail pointers are PTR_W bits wide and wrap modulo DEPTH.
- full and empty are derived from count, combinationally from registered state.
- Push is accepted when push=1, state=IDLE, and either count<DEPTH or a non-mispredicting pop occurs in the same cycle.
  - Push while full with no pop: dropped, err_overflow set.
  - Push in RECOVER: silently dropped; this is the expected squash, not an error.
- Resolve with resolve_valid=1 and count>0 pops the head. Outputs are registered, one cycle latency:
  - update=1, updatePC=head.pc, branchResult=resolve_taken.
  - If resolve_pc != head.pc: err_order set; the pop and training still use head.pc.
  - Correct prediction (resolve_taken == head.pred_taken): flush=0; count decrements unless a push is also accepted.
  - Misprediction: flush=1 and redirect_pc=head.alt_pc on the next cycle; the whole queue is cleared (count=0, head=tail); any same-cycle push is dropped; state goes to RECOVER; mispredict_count increments, saturating at 16'hFFFF.
- resolve_valid with count=0: no update, err_underflow set.
- update and flush are single-cycle pulses. updatePC, branchResult and redirect_pc hold their last values when no pulse is active.
- FSM:
  - IDLE -> RECOVER on misprediction.
  - RECOVER loads a counter with RECOVER_CYC-1, stall=1, and decrements the counter each cycle.
  - RECOVER -> IDLE after the counter reaches 0, so stall is high for exactly RECOVER_CYC cycles.
- resolve_valid in RECOVER: treated as underflow, since the queue is empty.
- rst mid-operation (including during RECOVER): returns everything to the reset state on the next edge. Pending pulses are dropped.

Test Plan:
- Reset then idle: empty=1, count=0, update=0, flush=0, stall=0, all err_*=0 after 1 cycle.
- Push pc=0x100 pred_taken=1 alt=0x108, then resolve taken=1 pc=0x100: the next cycle has update=1, updatePC=0x100, branchResult=1, flush=0; count returns to 0.
- Push 0x100(T, alt 0x108) and 0x200(NT, alt 0x240), then resolve 0x100 taken=0:
  - Next cycle: flush=1, redirect_pc=0x108, count=0, mispredict_count=1.
  - stall high for 2 cycles; a push during stall is dropped.
- Fill 4 entries, push a 5th with no pop: dropped, err_overflow=1. Then push and correct resolve in the same cycle while full: both accepted, count stays 4.
- Resolve on empty queue: err_underflow=1, update stays 0. Resolve with resolve_pc=0x300 while head=0x100: err_order=1, updatePC=0x100.
- Assert rst during RECOVER: stall=0, count=0, mispredict_count=0 after 1 cycle; a push the following cycle is accepted.
